input_port_req: RTL and testbench

INPUT_PORT_REQ -- requirements
Module: input_port_req

---
 rtl/input_port_req.sv | 134 +++++++++++++
 tb/tb_input_port_req.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_req.sv
// Router input port: 2-entry flit FIFO, XY route request to the output arbiters, grant handshake.
// Optional build macro IPR_GNT_CHECK_EN enables the sticky grant-protocol error flag on err.
module input_port_req (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic [4:0]  req,
    input  logic [4:0]  gnt,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StReq, StGrant} state_e;

    localparam logic [4:0] RouteN  = 5'b10000;
    localparam logic [4:0] RouteS  = 5'b01000;
    localparam logic [4:0] RouteE  = 5'b00100;
    localparam logic [4:0] RouteW  = 5'b00010;
    localparam logic [4:0] RoutePe = 5'b00001;

    state_e      state_q, state_d, cur_state;
    logic [63:0] mem_q [2];
    logic [63:0] mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_data_q, out_data_d;

    logic [63:0]       head;
    logic signed [3:0] hx, hy;
    logic [4:0]        route, route_req;
    logic [63:0]       stepped;
    logic              hit, push, pop;

    assign head = mem_q[rd_ptr_q];
    assign hx   = head[55:52];
    assign hy   = head[51:48];

    always_comb begin
        route = RoutePe;
        if (hx > 4'sd0)      route = RouteE;
        else if (hx < 4'sd0) route = RouteW;
        else if (hy > 4'sd0) route = RouteN;
        else if (hy < 4'sd0) route = RouteS;
    end

    // route_req is the request before the grant-cycle mask; the grant is matched against it.
    assign route_req = (state_q == StReq) ? route : 5'b00000;
    assign hit       = |(gnt & route_req);
    assign cur_state = (state_q == StReq && hit) ? StGrant : state_q;
    assign req       = (cur_state == StReq) ? route : 5'b00000;
    assign in_ready  = (count_q != 2'd2);
    assign push      = in_valid & in_ready;
    assign pop       = (cur_state == StGrant);

    always_comb begin
        stepped = head;
        unique case (route)
            RouteE:  stepped[55:52] = hx - 4'sd1;
            RouteW:  stepped[55:52] = hx + 4'sd1;
            RouteN:  stepped[51:48] = hy - 4'sd1;
            RouteS:  stepped[51:48] = hy + 4'sd1;
            default: stepped = head;
        endcase
    end

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = pop;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d   = ~rd_ptr_q;
            out_data_d = stepped;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        state_d = (count_d != 2'd0) ? StReq : StIdle;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef IPR_GNT_CHECK_EN
    logic err_q, err_d;
    logic gnt_stray, gnt_multi;

    assign gnt_stray = |(gnt & ~route_req);
    assign gnt_multi = |(gnt & (gnt - 5'd1));

    always_comb begin
        err_d = err_q | gnt_stray | gnt_multi;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_input_port_req.sv
// Self-checking bench for input_port_req: directed scenarios plus randomized traffic
// checked against a flit-queue reference model.
module tb_input_port_req;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [4:0]  req;
    logic [4:0]  gnt;
    logic        out_valid;
    logic [63:0] out_data;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef IPR_GNT_CHECK_EN
    localparam logic ErrEnabled = 1'b1;
`else
    localparam logic ErrEnabled = 1'b0;
`endif

    input_port_req dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .req       (req),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input int hx, input int hy, input logic [63:0] pl);
        logic [63:0] r;
        logic [31:0] x, y;
        x = hx;
        y = hy;
        r = pl;
        r[55:52] = x[3:0];
        r[51:48] = y[3:0];
        return r;
    endfunction

    function automatic int hop(input logic [3:0] f);
        return (f[3] == 1'b1) ? int'(f) - 16 : int'(f);
    endfunction

    // XY routing decided from signed hop values.
    function automatic logic [4:0] exp_route(input logic [63:0] f);
        int hx, hy;
        hx = hop(f[55:52]);
        hy = hop(f[51:48]);
        if (hx > 0) return 5'b00100;
        if (hx < 0) return 5'b00010;
        if (hy > 0) return 5'b10000;
        if (hy < 0) return 5'b01000;
        return 5'b00001;
    endfunction

    function automatic logic [63:0] exp_step(input logic [63:0] f);
        int hx, hy;
        hx = hop(f[55:52]);
        hy = hop(f[51:48]);
        if (hx > 0)      return mk(hx - 1, hy, f);
        else if (hx < 0) return mk(hx + 1, hy, f);
        else if (hy > 0) return mk(hx, hy - 1, f);
        else if (hy < 0) return mk(hx, hy + 1, f);
        return f;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        gnt      = '0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        gnt      = '0;
        cyc();
        #1;
        n_checks++;
        if (req !== 5'b0 || out_valid !== 1'b0 || out_data !== 64'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b ov=%b od=%h err=%b, want 0/0/0/0",
                     req, out_valid, out_data, err);
        end
        cyc();
        reset = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_east();
        logic [63:0] f;
        do_reset();
        f = mk(2, 0, 64'h0123_4567_89ab_cdef);
        in_valid = 1'b1;
        in_data  = f;
        #1;
        n_checks++;
        if (req !== 5'b0) begin n_fail++; $display("FAIL east_idle_req: got %b want 00000", req); end
        cyc();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (req !== 5'b00100) begin n_fail++; $display("FAIL east_req: got %b want 00100", req); end
        cyc();
        gnt = 5'b00100;
        #1;
        n_checks++;
        if (req !== 5'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL east_grant_cycle: req=%b ov=%b want 00000/0", req, out_valid);
        end
        cyc();
        gnt = 5'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== mk(1, 0, f)) begin
            n_fail++;
            $display("FAIL east_out: ov=%b od=%h want 1/%h", out_valid, out_data, mk(1, 0, f));
        end
        cyc();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || req !== 5'b0) begin
            n_fail++;
            $display("FAIL east_pulse: ov=%b req=%b want 0/00000", out_valid, req);
        end
    endtask

    task automatic test_pe();
        logic [63:0] f;
        do_reset();
        f = mk(0, 0, 64'hfeed_0000_0000_beef);
        in_valid = 1'b1;
        in_data  = f;
        cyc();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (req !== 5'b00001) begin n_fail++; $display("FAIL pe_req: got %b want 00001", req); end
        cyc();
        gnt = 5'b00001;
        cyc();
        gnt = 5'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== f) begin
            n_fail++;
            $display("FAIL pe_out: ov=%b od=%h want 1/%h", out_valid, out_data, f);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b;
        do_reset();
        a = mk(-1, 0, 64'h1111_2222_3333_4444);
        b = mk(0, -3, 64'h5555_6666_7777_8888);
        in_valid = 1'b1;
        in_data  = a;
        cyc();
        in_data = b;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || req !== 5'b00010) begin
            n_fail++;
            $display("FAIL b2b_first_req: rdy=%b req=%b want 1/00010", in_ready, req);
        end
        cyc();
        in_valid = 1'b0;
        gnt      = 5'b00010;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || req !== 5'b0) begin
            n_fail++;
            $display("FAIL b2b_full_grant: rdy=%b req=%b want 0/00000", in_ready, req);
        end
        cyc();
        gnt = 5'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== mk(0, 0, a) || req !== 5'b01000 || in_ready !== 1'b1)
        begin
            n_fail++;
            $display("FAIL b2b_out1: ov=%b od=%h req=%b rdy=%b want 1/%h/01000/1",
                     out_valid, out_data, req, in_ready, mk(0, 0, a));
        end
        cyc();
        gnt = 5'b01000;
        #1;
        n_checks++;
        if (req !== 5'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_grant2: req=%b ov=%b want 00000/0", req, out_valid);
        end
        cyc();
        gnt = 5'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== mk(0, -2, b) || req !== 5'b0) begin
            n_fail++;
            $display("FAIL b2b_out2: ov=%b od=%h req=%b want 1/%h/00000",
                     out_valid, out_data, req, mk(0, -2, b));
        end
    endtask

    task automatic test_hold();
        do_reset();
        in_valid = 1'b1;
        in_data  = mk(3, 1, 64'habcd);
        cyc();
        in_data = mk(0, 2, 64'hdcba);
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if (req !== 5'b00100 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: req=%b rdy=%b ov=%b want 00100/0/0",
                         i, req, in_ready, out_valid);
            end
            cyc();
        end
    endtask

    task automatic test_gnt_check();
        do_reset();
        in_valid = 1'b1;
        in_data  = mk(1, 0, 64'h77);
        cyc();
        in_valid = 1'b0;
        cyc();
        gnt = 5'b10000;
        #1;
        n_checks++;
        if (req !== 5'b00100) begin
            n_fail++;
            $display("FAIL err_req_kept: got %b want 00100", req);
        end
        cyc();
        gnt = 5'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (err !== ErrEnabled || out_valid !== 1'b0 || req !== 5'b00100) begin
                n_fail++;
                $display("FAIL err_sticky%0d: err=%b ov=%b req=%b want %b/0/00100",
                         i, err, out_valid, req, ErrEnabled);
            end
            cyc();
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_reset: got %b want 0", err); end
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1;
        in_data  = mk(1, 0, 64'h9);
        cyc();
        in_data = mk(0, 1, 64'ha);
        cyc();
        in_valid = 1'b0;
        gnt      = 5'b00100;
        #1;
        n_checks++;
        if (req !== 5'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_grant_cycle: req=%b rdy=%b want 00000/0", req, in_ready);
        end
        reset = 1'b0;
        cyc();
        gnt = 5'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_out: ov=%b want 0", out_valid);
        end
        cyc();
        reset = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || req !== 5'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: rdy=%b req=%b ov=%b want 1/00000/0",
                     in_ready, req, out_valid);
        end
        cyc();
        #1;
        n_checks++;
        if (req !== 5'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_empty: req=%b ov=%b want 00000/0", req, out_valid);
        end
    endtask

    task automatic test_random();
        logic [63:0] q[$];
        logic [4:0]  last_req, r, exp_req;
        logic        grant, exp_ready, exp_ov;
        logic [63:0] exp_od;
        do_reset();
        last_req = '0;
        exp_ov   = 1'b0;
        exp_od   = '0;
        for (int c = 0; c < 600; c++) begin
            gnt      = (last_req != 5'b0 && $urandom_range(0, 2) != 0) ? last_req : 5'b0;
            in_valid = ($urandom_range(0, 1) == 1);
            in_data  = {$urandom, $urandom};
            #1;
            exp_ready = (q.size() != 2);
            r         = (q.size() > 0) ? exp_route(q[0]) : 5'b0;
            grant     = (q.size() > 0) && ((gnt & r) != 5'b0);
            exp_req   = (q.size() > 0 && !grant) ? r : 5'b0;
            n_checks++;
            if (in_ready !== exp_ready || req !== exp_req || out_valid !== exp_ov || err !== 1'b0)
            begin
                n_fail++;
                $display("FAIL rand_ctl c%0d: rdy=%b req=%b ov=%b err=%b want %b/%b/%b/0",
                         c, in_ready, req, out_valid, err, exp_ready, exp_req, exp_ov);
            end
            if (exp_ov) begin
                n_checks++;
                if (out_data !== exp_od) begin
                    n_fail++;
                    $display("FAIL rand_data c%0d: got %h want %h", c, out_data, exp_od);
                end
            end
            exp_ov = grant;
            if (grant) begin
                exp_od = exp_step(q[0]);
                void'(q.pop_front());
            end
            if (in_valid && exp_ready) q.push_back(in_data);
            last_req = exp_req;
            cyc();
        end
        in_valid = 1'b0;
        gnt      = 5'b0;
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        gnt      = '0;
        test_reset();
        test_east();
        test_pe();
        test_back_to_back();
        test_hold();
        test_gnt_check();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
